// File: rtl/fp_normalize_round_pkg.sv
// Shared definitions for the FP32 post-add normalize/round stage.
//   - Default field widths and exponent constants
//   - FSM state encoding
//   - Guard/round/sticky bundle
//   - exp_max(): all-ones biased exponent for a given exponent width
package fp_pkg;

  localparam int EXP_W_DEFAULT  = 8;
  localparam int FRAC_W_DEFAULT = 23;
  localparam int EXP_MAX        = (1 << EXP_W_DEFAULT) - 1;
  localparam int BIAS           = 127;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    SHR,
    SHL,
    ROUND,
    OUT
  } state_t;

  // Packed so that {g, r, s} lines up with a 3-bit GRS bus, g in the MSB.
  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_normalize_round_if.sv
// Bus between the mantissa adder, the normalize/round stage and its consumer.
//   Upstream : in_valid/in_ready handshake carrying sign, z_flag, mant, GRS_in, exp_in
//   Downstream: out_valid/out_ready handshake carrying result and the three flags
// Modports:
//   master - the side that produces operands and consumes results
//   slave  - the normalize/round stage
interface fp_normalize_round_if
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEFAULT,
  parameter int FRAC_W = FRAC_W_DEFAULT
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    sign;
  logic                    z_flag;
  logic [FRAC_W+1:0]       mant;     // [FRAC_W+1]=carry, [FRAC_W]=hidden
  logic [2:0]              GRS_in;   // guard, round, sticky
  logic [EXP_W-1:0]        exp_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   result;
  logic                    overflow;
  logic                    underflow;
  logic                    inexact;

  modport master (
    output in_valid, sign, z_flag, mant, GRS_in, exp_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, sign, z_flag, mant, GRS_in, exp_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment on a normalized (or denormal) significand.
// Ports:
//   mant_i    - hidden bit + fraction
//   grs_i     - guard/round/sticky below the LSB
//   mant_o    - rounded significand (wraps to zero when carry_o is set)
//   carry_o   - increment overflowed out of the hidden bit position
//   inexact_o - any discarded bit was nonzero
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic [FRAC_W:0] mant_i,
  input  grs_t            grs_i,
  output logic [FRAC_W:0] mant_o,
  output logic            carry_o,
  output logic            inexact_o
);

  logic round_up;

  always_comb begin
    // Ties (G=1, R=S=0) only round up when that makes the LSB even.
    round_up            = grs_i.g & (grs_i.r | grs_i.s | mant_i[0]);
    {carry_o, mant_o}   = {1'b0, mant_i} + (FRAC_W + 2)'(round_up);
    inexact_o           = |grs_i;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add stage of the FP32 adder/subtractor: normalizes the raw adder
// output one bit per clock, rounds to nearest-even and packs an IEEE-754 word.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of fp_normalize_round_if (operand in, result out)
// Flow: IDLE -> NORM -> {SHR | SHL*} -> ROUND -> OUT -> IDLE.
// Zero operands skip straight from IDLE to OUT with +0 and no flags.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEFAULT,
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_normalize_round_if.slave  bus
);

  localparam int MANT_W = FRAC_W + 2;
  // One spare bit so exponent overflow after SHR/round carry is visible.
  localparam int EI_W   = EXP_W + 1;

  localparam logic [EI_W-1:0] EXP_ONE = EI_W'(1);
  localparam logic [EI_W-1:0] EXP_TWO = EI_W'(2);
  localparam logic [EI_W-1:0] EXP_INF = EI_W'(exp_max(EXP_W));

  state_t                 state_q;
  logic [MANT_W-1:0]      mant_q;
  grs_t                   grs_q;
  logic [EI_W-1:0]        exp_q;
  logic                   sign_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [EXP_W+FRAC_W:0]  result_q;
  logic                   overflow_q;
  logic                   underflow_q;
  logic                   inexact_q;

  // ---------------------------------------------------------------------------
  // Rounding and packing of the current significand
  // ---------------------------------------------------------------------------
  logic [FRAC_W:0]        rnd_mant;
  logic                   rnd_carry;
  logic                   rnd_inexact;

  fp_round_rne #(
    .FRAC_W (FRAC_W)
  ) u_round (
    .mant_i    (mant_q[FRAC_W:0]),
    .grs_i     (grs_q),
    .mant_o    (rnd_mant),
    .carry_o   (rnd_carry),
    .inexact_o (rnd_inexact)
  );

  logic [EI_W-1:0]        exp_rnd_d;
  logic                   hidden_d;
  logic [FRAC_W-1:0]      frac_d;
  logic [EI_W-1:0]        exp_pack_d;
  logic [EXP_W+FRAC_W:0]  result_d;
  logic                   overflow_d;
  logic                   underflow_d;
  logic                   inexact_d;

  always_comb begin
    // NOTE: every output of this block gets a value on every path before any
    // conditional override, so no latch can be inferred.
    // A rounding carry means the significand was all ones: the shifted-right
    // value is 1.000..0, so only the exponent changes.
    exp_rnd_d   = rnd_carry ? exp_q + EXP_ONE : exp_q;
    hidden_d    = rnd_carry | rnd_mant[FRAC_W];
    frac_d      = rnd_mant[FRAC_W-1:0];
    // Without a hidden bit the value is denormal and encodes with exponent 0;
    // a denormal that rounds up to 2^-126 gains its hidden bit here.
    exp_pack_d  = hidden_d ? exp_rnd_d : '0;
    result_d    = {sign_q, exp_pack_d[EXP_W-1:0], frac_d};
    overflow_d  = 1'b0;
    inexact_d   = rnd_inexact;
    underflow_d = (exp_pack_d == '0) & rnd_inexact;
    if (exp_pack_d >= EXP_INF) begin
      result_d    = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      overflow_d  = 1'b1;
      inexact_d   = 1'b1;
      underflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and shifter
  // ---------------------------------------------------------------------------
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others (the shift chains rely on it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      grs_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            sign_q     <= bus.sign;
            mant_q     <= bus.mant;
            grs_q      <= grs_t'(bus.GRS_in);
            // Exponent 0 is the denormal encoding of scale 2^-126, same as 1.
            exp_q      <= (bus.exp_in == '0) ? EXP_ONE : {1'b0, bus.exp_in};
            if (bus.z_flag || (bus.mant == '0 && bus.GRS_in == '0)) begin
              result_q    <= '0;
              overflow_q  <= 1'b0;
              underflow_q <= 1'b0;
              inexact_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              state_q <= NORM;
            end
          end
        end

        NORM: begin
          if (mant_q[FRAC_W+1]) begin
            state_q <= SHR;
          end else if (mant_q[FRAC_W] || exp_q == EXP_ONE) begin
            state_q <= ROUND;
          end else begin
            state_q <= SHL;
          end
        end

        SHR: begin
          mant_q  <= mant_q >> 1;
          grs_q   <= '{g: mant_q[0], r: grs_q.g, s: grs_q.r | grs_q.s};
          exp_q   <= exp_q + EXP_ONE;
          state_q <= ROUND;
        end

        SHL: begin
          // Guard bit re-enters the significand; sticky stays put because it
          // stands for every bit below it.
          mant_q <= {mant_q[MANT_W-2:0], grs_q.g};
          grs_q  <= '{g: grs_q.r, r: grs_q.s, s: grs_q.s};
          exp_q  <= exp_q - EXP_ONE;
          // Stop when the bit arriving at the hidden position is set, or the
          // exponent reaches the denormal floor.
          if (mant_q[FRAC_W-1] || exp_q == EXP_TWO) begin
            state_q <= ROUND;
          end
        end

        ROUND: begin
          mant_q      <= {1'b0, hidden_d, frac_d};
          exp_q       <= exp_rnd_d;
          result_q    <= result_d;
          overflow_q  <= overflow_d;
          underflow_q <= underflow_d;
          inexact_q   <= inexact_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end

        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;

endmodule
